psum_accumulator: RTL and testbench

//  Read-modify-write stage between the PE cluster's column outputs and the psum GLB.
//  On each compute_done pulse it captures X_dim column psums. If accumulation is

---
 rtl/psum_acc_pkg.sv | 18 +
 rtl/psum_accumulator.sv | 193 +++++++++++++++++++
 tb/tb_psum_accumulator.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_pkg.sv
// Shared types for the psum read-modify-write stage.
//   psum_acc_state_t : FSM state encoding used by psum_accumulator
//   psum_t           : default-width psum word
package psum_acc_pkg;

    localparam int unsigned PSUM_DATA_BITWIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE
    } psum_acc_state_t;

    typedef logic [PSUM_DATA_BITWIDTH-1:0] psum_t;

endpackage

// File: rtl/psum_accumulator.sv
// Read-modify-write stage between the PE cluster column outputs and the psum GLB.
// On a start pulse it captures X_dim column psums, then either writes them straight
// to the GLB or, for every column, reads the stored psum, adds the new value and
// writes the sum back, so multi-pass results build up in the GLB.
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   asynchronous active-low reset
//   r_data_spad_psum   in   X_dim column psums, column c at [c*DATA_BITWIDTH +: DATA_BITWIDTH]
//   write_psum_ctrl    in   start pulse (PE cluster compute_done)
//   accum_en           in   1 = add to stored psum, 0 = overwrite
//   psum_row           in   output-row index of this pass
//   read_req_glb_psum  out  GLB read request
//   r_addr_glb_psum    out  GLB read address
//   r_data_glb_psum    in   GLB read data, valid one cycle after read_req_glb_psum
//   write_en_glb_psum  out  GLB write enable
//   w_addr_glb_psum    out  GLB write address
//   w_data_glb_psum    out  GLB write data
//   busy               out  high while a pass is in progress
//   psum_done          out  one-cycle pulse after the last write
//   ovf_flag           out  sticky: some sum wrapped in this pass
//   drop_flag          out  sticky: a start pulse arrived while not idle
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH     = 16,
    parameter int unsigned ADDR_BITWIDTH_GLB = 10,
    parameter int unsigned X_dim             = 3,
    parameter int unsigned ROW_BITWIDTH      = 4,
    parameter int unsigned PSUM_LOAD_ADDR    = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_BITWIDTH*X_dim-1:0]   r_data_spad_psum,
    input  logic                             write_psum_ctrl,
    input  logic                             accum_en,
    input  logic [ROW_BITWIDTH-1:0]          psum_row,
    output logic                             read_req_glb_psum,
    output logic [ADDR_BITWIDTH_GLB-1:0]     r_addr_glb_psum,
    input  logic [DATA_BITWIDTH-1:0]         r_data_glb_psum,
    output logic                             write_en_glb_psum,
    output logic [ADDR_BITWIDTH_GLB-1:0]     w_addr_glb_psum,
    output logic [DATA_BITWIDTH-1:0]         w_data_glb_psum,
    output logic                             busy,
    output logic                             psum_done,
    output logic                             ovf_flag,
    output logic                             drop_flag
);

    localparam int unsigned COL_BITWIDTH = (X_dim > 1) ? $clog2(X_dim) : 1;
    localparam logic [COL_BITWIDTH-1:0] LAST_COL = COL_BITWIDTH'(X_dim - 1);

    psum_acc_state_t state_q, state_d;
    logic [COL_BITWIDTH-1:0]      col_q, col_d;
    logic                         acc_q;
    logic [ROW_BITWIDTH-1:0]      row_q;
    logic [DATA_BITWIDTH-1:0]     cap_q [X_dim];

    logic                         read_req_q, read_req_d;
    logic [ADDR_BITWIDTH_GLB-1:0] r_addr_q, r_addr_d;
    logic                         write_en_q, write_en_d;
    logic [ADDR_BITWIDTH_GLB-1:0] w_addr_q, w_addr_d;
    logic [DATA_BITWIDTH-1:0]     w_data_q, w_data_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         ovf_q, ovf_d;
    logic                         drop_q, drop_d;

    logic                         trigger;
    logic [DATA_BITWIDTH:0]       sum;
    logic [ROW_BITWIDTH-1:0]      row_sel;
    logic [DATA_BITWIDTH-1:0]     wr_src;

    function automatic logic [ADDR_BITWIDTH_GLB-1:0] glb_addr(
        input logic [ROW_BITWIDTH-1:0] row,
        input logic [COL_BITWIDTH-1:0] col
    );
        logic [31:0] full;
        full = PSUM_LOAD_ADDR + 32'(row) * X_dim + 32'(col);
        return full[ADDR_BITWIDTH_GLB-1:0];
    endfunction

    assign trigger = write_psum_ctrl && (state_q == IDLE);

    // GLB data returns during WAIT, so the sum is ready for the WAIT->WR edge.
    assign sum = {1'b0, cap_q[col_q]} + {1'b0, r_data_glb_psum};

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (write_psum_ctrl) begin
                    state_d = accum_en ? RD : WR;
                    col_d   = '0;
                end
            end
            RD:   state_d = WAIT;
            WAIT: state_d = WR;
            WR: begin
                if (col_q == LAST_COL) begin
                    state_d = DONE;
                end else begin
                    state_d = acc_q ? RD : WR;
                    col_d   = col_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes appear the cycle
    // after the transition that schedules them and addresses/data hold otherwise.
    always_comb begin
        // On the accepting edge the capture buffer is not loaded yet; use live inputs.
        row_sel = (state_q == IDLE) ? psum_row : row_q;
        wr_src  = (state_q == IDLE) ? r_data_spad_psum[DATA_BITWIDTH-1:0] : cap_q[col_d];

        read_req_d = (state_d == RD);
        r_addr_d   = read_req_d ? glb_addr(row_sel, col_d) : r_addr_q;

        write_en_d = (state_d == WR);
        w_addr_d   = write_en_d ? glb_addr(row_sel, col_d) : w_addr_q;
        w_data_d   = w_data_q;
        if (write_en_d) begin
            w_data_d = (state_q == WAIT) ? sum[DATA_BITWIDTH-1:0] : wr_src;
        end

        busy_d = (state_d == RD) || (state_d == WAIT) || (state_d == WR);
        done_d = (state_d == DONE);

        ovf_d = ovf_q;
        if (trigger) begin
            ovf_d = 1'b0;
        end else if ((state_q == WAIT) && sum[DATA_BITWIDTH]) begin
            ovf_d = 1'b1;
        end

        drop_d = drop_q || (write_psum_ctrl && (state_q != IDLE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            acc_q      <= 1'b0;
            row_q      <= '0;
            for (int c = 0; c < int'(X_dim); c++) begin
                cap_q[c] <= '0;
            end
            read_req_q <= 1'b0;
            r_addr_q   <= '0;
            write_en_q <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            if (trigger) begin
                acc_q <= accum_en;
                row_q <= psum_row;
                for (int c = 0; c < int'(X_dim); c++) begin
                    cap_q[c] <= r_data_spad_psum[c*DATA_BITWIDTH +: DATA_BITWIDTH];
                end
            end
            read_req_q <= read_req_d;
            r_addr_q   <= r_addr_d;
            write_en_q <= write_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    assign read_req_glb_psum = read_req_q;
    assign r_addr_glb_psum   = r_addr_q;
    assign write_en_glb_psum = write_en_q;
    assign w_addr_glb_psum   = w_addr_q;
    assign w_data_glb_psum   = w_data_q;
    assign busy              = busy_q;
    assign psum_done         = done_q;
    assign ovf_flag          = ovf_q;
    assign drop_flag         = drop_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed passes followed by randomized passes, all
// checked cycle by cycle against a pass-level reference model and a GLB model.
module tb_psum_accumulator;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int XD = 3;
    localparam int RW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW*XD-1:0]  r_data_spad_psum;
    logic              write_psum_ctrl;
    logic              accum_en;
    logic [RW-1:0]     psum_row;
    logic              read_req_glb_psum;
    logic [AW-1:0]     r_addr_glb_psum;
    logic [DW-1:0]     r_data_glb_psum = '0;
    logic              write_en_glb_psum;
    logic [AW-1:0]     w_addr_glb_psum;
    logic [DW-1:0]     w_data_glb_psum;
    logic              busy;
    logic              psum_done;
    logic              ovf_flag;
    logic              drop_flag;

    psum_accumulator #(
        .DATA_BITWIDTH    (DW),
        .ADDR_BITWIDTH_GLB(AW),
        .X_dim            (XD),
        .ROW_BITWIDTH     (RW),
        .PSUM_LOAD_ADDR   (0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .r_data_spad_psum (r_data_spad_psum),
        .write_psum_ctrl  (write_psum_ctrl),
        .accum_en         (accum_en),
        .psum_row         (psum_row),
        .read_req_glb_psum(read_req_glb_psum),
        .r_addr_glb_psum  (r_addr_glb_psum),
        .r_data_glb_psum  (r_data_glb_psum),
        .write_en_glb_psum(write_en_glb_psum),
        .w_addr_glb_psum  (w_addr_glb_psum),
        .w_data_glb_psum  (w_data_glb_psum),
        .busy             (busy),
        .psum_done        (psum_done),
        .ovf_flag         (ovf_flag),
        .drop_flag        (drop_flag)
    );

    always #5 clk = ~clk;

    // GLB model: 1-cycle read latency, plus a bench-side preload port.
    logic [DW-1:0] glb [1024] = '{default: '0};
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) glb[pl_addr] <= pl_data;
        if (write_en_glb_psum) glb[w_addr_glb_psum] <= w_data_glb_psum;
        if (read_req_glb_psum) r_data_glb_psum <= glb[r_addr_glb_psum];
    end

    // Reference memory contents and expected sticky/held output values.
    logic [DW-1:0] ref_mem [1024] = '{default: '0};
    logic          drop_exp = 1'b0;
    logic [AW-1:0] last_raddr = '0;
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic e_rd, input logic [AW-1:0] e_ra,
                             input logic e_wr, input logic [AW-1:0] e_wa,
                             input logic [DW-1:0] e_wd, input logic e_busy,
                             input logic e_done, input logic e_ovf);
        if (e_rd) last_raddr = e_ra;
        if (e_wr) begin
            last_waddr = e_wa;
            last_wdata = e_wd;
        end
        chk({tag, " strobes"}, 32'({read_req_glb_psum, write_en_glb_psum, busy, psum_done}),
            32'({e_rd, e_wr, e_busy, e_done}));
        chk({tag, " r_addr"}, 32'(r_addr_glb_psum), 32'(last_raddr));
        chk({tag, " w_addr"}, 32'(w_addr_glb_psum), 32'(last_waddr));
        chk({tag, " w_data"}, 32'(w_data_glb_psum), 32'(last_wdata));
        chk({tag, " flags"}, 32'({ovf_flag, drop_flag}), 32'({e_ovf, drop_exp}));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctl"}, 32'({read_req_glb_psum, write_en_glb_psum, busy, psum_done,
                                ovf_flag, drop_flag}), 32'(0));
        chk({tag, " addr"}, 32'({r_addr_glb_psum, w_addr_glb_psum}), 32'(0));
        chk({tag, " data"}, 32'(w_data_glb_psum), 32'(0));
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[addr] = data;
    endtask

    function automatic int wcyc(input logic acc, input int c);
        return acc ? 3 * c + 3 : c + 1;
    endfunction

    // One pass. drop_at: cycle during which a stray start pulse is held (0 = none).
    // abort_at: cycle at whose middle reset is asserted (0 = none).
    task automatic run_pass(input string tag, input logic acc, input logic [RW-1:0] row,
                            input logic [DW*XD-1:0] pe_vec, input int drop_at,
                            input int abort_at);
        logic [AW-1:0] a [XD];
        logic [DW-1:0] wd [XD];
        logic          cy [XD];
        logic [DW:0]   s;
        int            ncyc, col;
        logic          e_rd, e_wr, e_busy, e_done, e_ovf;
        logic [AW-1:0] e_ra, e_wa;
        logic [DW-1:0] e_wd;

        for (int c = 0; c < XD; c++) begin
            a[c] = AW'(int'(row) * XD + c);
            if (acc) begin
                s = {1'b0, ref_mem[a[c]]} + {1'b0, pe_vec[c*DW +: DW]};
                wd[c] = s[DW-1:0];
                cy[c] = s[DW];
            end else begin
                wd[c] = pe_vec[c*DW +: DW];
                cy[c] = 1'b0;
            end
        end
        ncyc = acc ? 3 * XD + 1 : XD + 1;

        @(negedge clk);
        write_psum_ctrl  = 1'b1;
        accum_en         = acc;
        psum_row         = row;
        r_data_spad_psum = pe_vec;

        for (int k = 1; k <= ncyc + 1; k++) begin
            @(negedge clk);
            // Scramble inputs to show only the trigger-edge values matter.
            write_psum_ctrl  = 1'b0;
            accum_en         = 1'($urandom_range(0, 1));
            psum_row         = RW'($urandom);
            r_data_spad_psum = {DW'($urandom), DW'($urandom), DW'($urandom)};

            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                chk_all_zero({tag, " abort"});
                for (int c = 0; c < XD; c++) begin
                    if (wcyc(acc, c) < k) ref_mem[a[c]] = wd[c];
                end
                drop_exp   = 1'b0;
                last_raddr = '0;
                last_waddr = '0;
                last_wdata = '0;
                repeat (2) begin
                    @(negedge clk);
                    chk_cycle({tag, " in reset"}, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                reset = 1'b1;
                @(negedge clk);
                chk_cycle({tag, " post reset"}, 0, 0, 0, 0, 0, 0, 0, 0);
                for (int c = 0; c < XD; c++) begin
                    chk({tag, " mem"}, 32'(glb[a[c]]), 32'(ref_mem[a[c]]));
                end
                return;
            end

            e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0;
            e_ra = '0; e_wa = '0; e_wd = '0;
            if (k < ncyc) begin
                e_busy = 1;
                if (acc) begin
                    col  = (k - 1) / 3;
                    e_rd = ((k - 1) % 3) == 0;
                    e_wr = ((k - 1) % 3) == 2;
                end else begin
                    col  = k - 1;
                    e_wr = 1;
                end
                e_ra = a[col];
                e_wa = a[col];
                e_wd = wd[col];
            end else if (k == ncyc) begin
                e_done = 1;
            end
            e_ovf = 0;
            for (int c = 0; c < XD; c++) begin
                if (cy[c] && wcyc(acc, c) <= k) e_ovf = 1;
            end
            if (drop_at != 0 && k == drop_at + 1) drop_exp = 1'b1;
            chk_cycle($sformatf("%s c%0d", tag, k), e_rd, e_ra, e_wr, e_wa, e_wd, e_busy,
                      e_done, e_ovf);
            if (k == drop_at) write_psum_ctrl = 1'b1;
        end

        for (int c = 0; c < XD; c++) begin
            ref_mem[a[c]] = wd[c];
            chk({tag, " mem"}, 32'(glb[a[c]]), 32'(ref_mem[a[c]]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic          acc;
        logic [RW-1:0] row;

        reset            = 1'b0;
        write_psum_ctrl  = 1'b0;
        accum_en         = 1'b0;
        psum_row         = '0;
        r_data_spad_psum = '0;

        // Reset held: inputs toggling, outputs stay at zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_all_zero("reset hold");
            write_psum_ctrl  = 1'($urandom_range(0, 1));
            accum_en         = 1'($urandom_range(0, 1));
            psum_row         = RW'($urandom);
            r_data_spad_psum = {DW'($urandom), DW'($urandom), DW'($urandom)};
        end
        @(negedge clk);
        write_psum_ctrl = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Overwrite pass.
        run_pass("t2 overwrite", 1'b0, 4'd0, {16'd30, 16'd20, 16'd10}, 0, 0);

        // Accumulate pass on row 1.
        preload(10'd3, 16'd10); preload(10'd4, 16'd20); preload(10'd5, 16'd30);
        run_pass("t3 accum", 1'b1, 4'd1, {16'd3, 16'd2, 16'd1}, 0, 0);

        // Wrap-around sets ovf_flag.
        preload(10'd0, 16'hFFFF);
        run_pass("t4 wrap", 1'b1, 4'd0, {16'd0, 16'd0, 16'd2}, 0, 0);
        chk("t4 ovf sticky", 32'(ovf_flag), 32'(1));

        // Stray trigger two cycles into an accumulate pass.
        preload(10'd3, 16'd10); preload(10'd4, 16'd20); preload(10'd5, 16'd30);
        run_pass("t5 drop", 1'b1, 4'd1, {16'd3, 16'd2, 16'd1}, 2, 0);

        // Stray trigger while in DONE is also dropped.
        run_pass("t5b drop done", 1'b0, 4'd2, {16'd7, 16'd8, 16'd9}, 4, 0);

        // Reset during WAIT of column 1.
        preload(10'd3, 16'd10); preload(10'd4, 16'd20); preload(10'd5, 16'd30);
        run_pass("t6 abort", 1'b1, 4'd1, {16'd3, 16'd2, 16'd1}, 0, 5);

        // Randomized passes.
        for (int i = 0; i < 12; i++) begin
            acc = 1'($urandom_range(0, 1));
            row = RW'($urandom);
            if (acc) preload(AW'(int'(row) * XD), DW'($urandom));
            run_pass($sformatf("rand%0d", i), acc, row,
                     {DW'($urandom), DW'($urandom), DW'($urandom)},
                     (i % 4 == 3) ? int'($urandom_range(1, 4)) : 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
